// File: rtl/debounce_toggle_if.sv
// Button-conditioning bundle: raw level in, debounced level and edge pulses out.
// Signals: btn_in (raw async level), d_out (debounced level), rise/fall (1-cycle
// accepted-edge pulses), t_pulse (toggle enable), busy (candidate being qualified).
interface debounce_toggle_if;
  logic btn_in;
  logic d_out;
  logic rise;
  logic fall;
  logic t_pulse;
  logic busy;

  // master drives the raw button and observes the conditioned outputs
  modport master (
    output btn_in,
    input  d_out, rise, fall, t_pulse, busy
  );

  // slave is the conditioning stage itself
  modport slave (
    input  btn_in,
    output d_out, rise, fall, t_pulse, busy
  );
endinterface

// File: rtl/debounce_toggle.sv
// Purpose: synchronise and debounce a raw button level; emit clean level + edge pulses.
// Latency: d_out/rise/fall update SYNC_STAGES-1+STABLE_CYCLES edges after the first sampling edge.
// Backpressure: none; free-running, outputs are registered every cycle.
//
// Ports: clk, rstn (async active-low); bus (slave modport): btn_in in;
//        d_out, rise, fall, t_pulse, busy out.
// Optional feature: define DEBOUNCE_TOGGLE_OUT_EN to get t_pulse as a registered
// copy of rise (one T-flop toggle per press); otherwise t_pulse is tied low.
module debounce_toggle #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 10,
  parameter int CNT_WIDTH     = 4
) (
  input  logic              clk,
  input  logic              rstn,
  debounce_toggle_if.slave  bus
);

  // Elaboration-time parameter guards
  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("debounce_toggle: SYNC_STAGES must be 2 or 3");
    end
    if (STABLE_CYCLES < 1 || STABLE_CYCLES >= (1 << CNT_WIDTH)) begin : g_bad_stable
      $error("debounce_toggle: STABLE_CYCLES must be in 1 .. 2**CNT_WIDTH-1");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  // Count value on which the next agreeing sample completes qualification
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'b00,
    CHECK_HIGH = 2'b01,
    IDLE_HIGH  = 2'b10,
    CHECK_LOW  = 2'b11
  } state_t;

  // ---------------- synchroniser ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------- qualification FSM ----------------
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 d_q, d_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 busy_q, busy_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      IDLE_LOW: begin
        cnt_d = '0;
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            // single-cycle qualification: accept on first agreeing sample
            state_d = IDLE_HIGH;
            d_d     = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = CHECK_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
      end

      CHECK_HIGH: begin
        // a reverted sample wins over a count that would complete this edge
        if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          d_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      IDLE_HIGH: begin
        cnt_d = '0;
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = IDLE_LOW;
            d_d     = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = CHECK_LOW;
            cnt_d   = CNT_ONE;
          end
        end
      end

      CHECK_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          d_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        // unreachable encodings fall back to the reset state
        state_d = IDLE_LOW;
        cnt_d   = '0;
        d_d     = 1'b0;
      end
    endcase

    // busy is registered from the next state so it lines up with the state register
    busy_d = (state_d == CHECK_HIGH) || (state_d == CHECK_LOW);
  end

  assign bus.d_out = d_q;
  assign bus.rise  = rise_q;
  assign bus.fall  = fall_q;
  assign bus.busy  = busy_q;

  // ---------------- toggle-enable output ----------------
`ifdef DEBOUNCE_TOGGLE_OUT_EN
  logic t_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t_q <= 1'b0;
    end else begin
      t_q <= rise_q;
    end
  end

  assign bus.t_pulse = t_q;
`else
  assign bus.t_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_toggle.sv
// Bench for debounce_toggle: default instance checked with a segment table and an
// event scoreboard; a STABLE_CYCLES=1 instance checked every cycle against the
// synchronised input delayed by one edge.
module tb_debounce_toggle;

  // stimulus applied just after edge n is first sampled at n+1; pulse appears after edge n+12
  localparam int LAT = 2 + 10;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic btn  = 1'b0;
  int   cyc  = 0;

  int n_checks = 0;
  int n_fail   = 0;

  debounce_toggle_if bus0 ();
  debounce_toggle_if bus1 ();

  assign bus0.btn_in = btn;
  assign bus1.btn_in = btn;

  debounce_toggle dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus0)
  );

  debounce_toggle #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (1),
    .CNT_WIDTH     (4)
  ) dut1 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 1 = rise, 2 = fall
    int cyc;
  } evt_t;

  evt_t evq[$];

  typedef struct {
    logic lvl;
    int   hold;
    int   evt;
    int   busy;
    logic d_end;
  } seg_t;

  seg_t segs[15];

  bit       mon_en     = 1'b0;
  logic     prev_rise0 = 1'b0;
  logic     prev_rise1 = 1'b0;
  logic [3:0] bh       = 4'b0;
  logic     tq         = 1'b0;
  int       exp_rises  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // btn as sampled by each edge; bh[2] is the level the 1-cycle instance must show
  always @(posedge clk or negedge rstn) begin
    if (!rstn) bh <= 4'b0;
    else       bh <= {bh[2:0], btn};
  end

  // downstream T flip-flop
  always @(posedge clk) begin
    if (bus0.t_pulse) tq <= ~tq;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus0.rise || bus0.fall) begin
        check("rise_fall_exclusive", {31'b0, bus0.rise & bus0.fall}, 32'd0);
        if (evq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: rise=%0b fall=%0b at cycle %0d, required none",
                   bus0.rise, bus0.fall, cyc);
        end else begin
          evt_t e;
          e = evq.pop_front();
          check("pulse_kind", bus0.rise ? 32'd1 : 32'd2, e.kind);
          check("pulse_cycle", cyc, e.cyc);
        end
      end
`ifdef DEBOUNCE_TOGGLE_OUT_EN
      check("t_pulse", {31'b0, bus0.t_pulse}, {31'b0, prev_rise0});
      check("b1_t_pulse", {31'b0, bus1.t_pulse}, {31'b0, prev_rise1});
`else
      check("t_pulse_off", {31'b0, bus0.t_pulse}, 32'd0);
      check("b1_t_pulse_off", {31'b0, bus1.t_pulse}, 32'd0);
`endif
      prev_rise0 = bus0.rise;
      prev_rise1 = bus1.rise;
      check("b1_d_out", {31'b0, bus1.d_out}, {31'b0, bh[2]});
      check("b1_rise",  {31'b0, bus1.rise},  {31'b0, bh[2] & ~bh[3]});
      check("b1_fall",  {31'b0, bus1.fall},  {31'b0, ~bh[2] & bh[3]});
      check("b1_busy",  {31'b0, bus1.busy},  32'd0);
    end
  end

  function automatic logic exp_tq();
`ifdef DEBOUNCE_TOGGLE_OUT_EN
    return exp_rises[0];
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge: drive the level, then observe hold cycles.
  task automatic apply_seg(input int idx, input logic lvl, input int hold, input int evt,
                           input int busy_exp, input logic d_exp);
    int nstart;
    int bc;
    btn    = lvl;
    nstart = cyc;
    if (evt != 0) begin
      evq.push_back('{evt, nstart + LAT});
      if (evt == 1) exp_rises++;
    end
    bc = 0;
    repeat (hold) begin
      @(negedge clk);
      if (bus0.busy === 1'b1) bc++;
    end
    if (busy_exp >= 0) check($sformatf("seg%0d_busy_cycles", idx), bc, busy_exp);
    check($sformatf("seg%0d_d_out", idx), {31'b0, bus0.d_out}, {31'b0, d_exp});
    check($sformatf("seg%0d_tq", idx), {31'b0, tq}, {31'b0, exp_tq()});
  endtask

  initial begin
    int r;
    // clean press, release, short glitch, bounce 1,0,1,1,0 then steady 1,
    // low for STABLE-1 (rejected), low for exactly STABLE (accepted), press, release
    segs[0]  = '{1'b1, 30, 1,  9, 1'b1};
    segs[1]  = '{1'b0, 30, 2,  9, 1'b0};
    segs[2]  = '{1'b1,  6, 0,  4, 1'b0};
    segs[3]  = '{1'b0, 20, 0,  2, 1'b0};
    segs[4]  = '{1'b1,  1, 0,  0, 1'b0};
    segs[5]  = '{1'b0,  1, 0,  0, 1'b0};
    segs[6]  = '{1'b1,  1, 0,  1, 1'b0};
    segs[7]  = '{1'b1,  1, 0,  0, 1'b0};
    segs[8]  = '{1'b0,  1, 0,  1, 1'b0};
    segs[9]  = '{1'b1, 30, 1, 10, 1'b1};
    segs[10] = '{1'b0,  9, 0,  7, 1'b1};
    segs[11] = '{1'b1, 20, 0,  2, 1'b1};
    segs[12] = '{1'b0, 10, 2,  8, 1'b1};
    segs[13] = '{1'b1, 30, 1, 10, 1'b1};
    segs[14] = '{1'b0, 30, 2,  9, 1'b0};

    rstn = 1'b0;
    btn  = 1'b0;
    #3;
    check("reset_d_out",   {31'b0, bus0.d_out},   32'd0);
    check("reset_rise",    {31'b0, bus0.rise},    32'd0);
    check("reset_fall",    {31'b0, bus0.fall},    32'd0);
    check("reset_t_pulse", {31'b0, bus0.t_pulse}, 32'd0);
    check("reset_busy",    {31'b0, bus0.busy},    32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn   = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply_seg(i, segs[i].lvl, segs[i].hold, segs[i].evt, segs[i].busy, segs[i].d_end);
    end

    // reset while a press is at count 5
    btn = 1'b1;
    repeat (7) @(negedge clk);
    check("mid_count_busy", {31'b0, bus0.busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("mid_reset_d_out",   {31'b0, bus0.d_out},   32'd0);
    check("mid_reset_rise",    {31'b0, bus0.rise},    32'd0);
    check("mid_reset_fall",    {31'b0, bus0.fall},    32'd0);
    check("mid_reset_t_pulse", {31'b0, bus0.t_pulse}, 32'd0);
    check("mid_reset_busy",    {31'b0, bus0.busy},    32'd0);
    check("mid_reset_b1_d_out", {31'b0, bus1.d_out},  32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    r    = cyc;
    evq.push_back('{1, r + LAT});
    exp_rises++;
    repeat (20) @(negedge clk);
    check("post_reset_d_out", {31'b0, bus0.d_out}, 32'd1);
    apply_seg(15, 1'b0, 30, 2, 9, 1'b0);

    check("events_outstanding", evq.size(), 32'd0);
    check("final_tq", {31'b0, tq}, {31'b0, exp_tq()});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_toggle.md
# debounce_toggle

Input-conditioning stage that sits directly upstream of the D/T flip-flop stage: it synchronises a raw, bouncy push-button or switch level, debounces it, and produces a clean level for a D input plus single-cycle edge pulses. One of those pulses is suited to driving a T input. All outputs are registered, so the downstream flip-flop samples glitch-free signals in the same clock domain.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth; legal values are 2 or 3.
- `STABLE_CYCLES`, default 10: number of consecutive cycles a new level must hold before it is accepted; legal range is 1 to 2^CNT_WIDTH−1.
- `CNT_WIDTH`, default 4: stability counter width.

- `clk`  input  1: single clock; all state updates on its rising edge.
- `rstn`  input  1: asynchronous, active-low reset.
- `btn_in`  input  1: raw asynchronous input.
- `d_out`  output  1: debounced level; intended to feed the flip-flop `d` input.
- `rise`  output  1: one-cycle pulse on an accepted 0→1 change.
- `fall`  output  1: one-cycle pulse on an accepted 1→0 change.
- `t_pulse`  output  1: toggle-enable pulse for a T flip-flop (see Configuration).
- `busy`  output  1: high while a candidate change is being qualified.

## Operation
- **Synchroniser.** `btn_in` passes through a chain of SYNC_STAGES flops. The chain output is `s`.
- **FSM states:** IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW.
- **IDLE_LOW** (`d_out`=0):
  - `s`=1: go to CHECK_HIGH and set the counter to 1.
  - If STABLE_CYCLES=1, go directly to IDLE_HIGH instead.
- **CHECK_HIGH:**
  - `s`=1: counter increments.
  - When the counter would reach STABLE_CYCLES, go to IDLE_HIGH. On that same edge, `d_out`←1, `rise`←1, and the counter clears.
  - `s`=0 (glitch): return to IDLE_LOW and clear the counter. No output change.
- **IDLE_HIGH / CHECK_LOW:** mirror images of IDLE_LOW / CHECK_HIGH, with `fall` pulsing and `d_out`←0.
- **Outputs.**
  - `busy` = 1 in CHECK_HIGH and CHECK_LOW.
  - `rise`, `fall`, `t_pulse` are high for exactly one cycle, then return to 0.
  - `rise` and `fall` are never high together.
- **Counter width.** The counter never exceeds STABLE_CYCLES, so there is no wrap.
- **Illegal parameters.** If STABLE_CYCLES ≥ 2^CNT_WIDTH, the design is illegal. Elaboration must fail via a generate-time check.
- **Illegal FSM encodings** recover to IDLE_LOW on the next edge.

## Timing
- **Reset values** (while `rstn`=0; reset is asynchronous):
  - All synchroniser flops = 0.
  - `d_out`=0, `rise`=0, `fall`=0, `t_pulse`=0, `busy`=0.
  - Counter = 0, state = IDLE_LOW.
- **Latency.**
  - Edge E0 is the first rising edge that samples the new `btn_in` level.
  - `s` changes after edge E0+SYNC_STAGES−1.
  - `d_out` and the edge pulse update at E0+SYNC_STAGES−1+STABLE_CYCLES.
  - With defaults this is 11 edges after E0.
- **Glitch rejection.** A change on `s` lasting fewer than STABLE_CYCLES consecutive cycles never changes `d_out`.
- **Reset mid-qualification.** Asserting `rstn` clears the counter immediately. After release, the input is qualified again from IDLE_LOW.
  - A high input held through reset produces `rise` after the full latency measured from the first post-release edge.
- **Simultaneous events.** The count resolves on the same edge that `s` reverts. The reverted `s` wins: the count restarts and there is no output change.

## Configuration
- Macro: `DEBOUNCE_TOGGLE_OUT_EN`.
- **Defined:** `t_pulse` is a registered copy of `rise`, i.e. one pulse per accepted press.
  - It is suitable as the T input of the downstream flip-flop, which then toggles once per press.
- **Undefined:** `t_pulse` is tied to 0 and its register is not instantiated. All other behaviour is unchanged.

## Test plan
- **Clean press.** Defaults; reset for 5 ns, then `btn_in`=1 held for 30 cycles.
  - Required: `d_out` rises exactly 11 edges after the first sampling edge.
  - `rise` is high for exactly 1 cycle; `busy` is high for the 9 cycles before acceptance.
- **Short glitch.** `btn_in` high for 6 cycles, then low.
  - Required: `d_out` stays 0, with no `rise` and no `fall`.
  - `busy` drops 2 cycles after `btn_in` falls.
- **Bounce.** Pattern 1,0,1,1,0,1 (one cycle each), then steady 1.
  - Required: exactly one `rise`, 11 edges after the start of the steady 1.
  - A later steady 0 produces exactly one `fall`.
- **Reset mid-count.** Assert `rstn`=0 at count 5 while `btn_in`=1, release after 2 cycles.
  - Required: all outputs are 0 immediately on reset.
  - `rise` occurs a full 11 edges after the first post-release edge.
- **Toggle mode.** With `DEBOUNCE_TOGGLE_OUT_EN` defined, apply two clean presses.
  - Required: two `t_pulse` pulses, each one cycle after the corresponding `rise`.
  - The downstream T flip-flop `q` goes 0→1→0.
  - With the macro undefined, `t_pulse` stays 0.
- **Boundary.** STABLE_CYCLES=1.
  - Required: `d_out` follows `s` with 1-cycle delay.
  - `busy` is never asserted.
